// File: rtl/dncnt8_timer.sv
// Programmable down-counting timer: one-shot or periodic, paced by en,
// with a registered terminal-count pulse and a borrow/underflow flag.
module dncnt8_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             en,
   input  logic             mode,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] step,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tc,
   output logic             uflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] reload_reg, reload_next;
   logic [WIDTH-1:0] step_reg, step_next;
   logic             mode_reg, mode_next;
   logic             tc_reg, tc_next;
   logic             uflow_reg, uflow_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;

   logic [WIDTH-1:0] step_inv;
   logic [WIDTH-1:0] diff;
   logic [WIDTH:0]   carry;
   logic             borrow;
   logic             terminal;
   logic             start_ok;

   // Subtraction as count + ~step + 1; a missing carry-out means a borrow.
   assign step_inv = ~step_reg;
   assign carry[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_sub
         assign diff[gi]      = count_reg[gi] ^ step_inv[gi] ^ carry[gi];
         assign carry[gi + 1] = (count_reg[gi] & step_inv[gi]) |
                                (carry[gi] & (count_reg[gi] ^ step_inv[gi]));
      end
   endgenerate

   assign borrow   = ~carry[WIDTH];
   assign terminal = borrow | (diff == '0);
   assign start_ok = start & (load_val != '0) & (step != '0);

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      reload_next = reload_reg;
      step_next   = step_reg;
      mode_next   = mode_reg;
      uflow_next  = uflow_reg;
      tc_next     = 1'b0;

      case (state_reg)
         IDLE, DONE: begin
            if (start_ok) begin
               count_next  = load_val;
               reload_next = load_val;
               step_next   = step;
               mode_next   = mode;
               uflow_next  = 1'b0;
               state_next  = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (en) begin
               if (terminal) begin
                  tc_next    = 1'b1;
                  uflow_next = borrow;
                  if (mode_reg) begin
                     count_next = reload_reg;
                  end else begin
                     count_next = '0;
                     state_next = DONE;
                  end
               end else begin
                  count_next = diff;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next == RUN);
      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         reload_reg <= '0;
         step_reg   <= '0;
         mode_reg   <= 1'b0;
         tc_reg     <= 1'b0;
         uflow_reg  <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         reload_reg <= reload_next;
         step_reg   <= step_next;
         mode_reg   <= mode_next;
         tc_reg     <= tc_next;
         uflow_reg  <= uflow_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   assign count = count_reg;
   assign busy  = busy_reg;
   assign done  = done_reg;
   assign tc    = tc_reg;
   assign uflow = uflow_reg;

endmodule

// File: tb/tb_dncnt8_timer.sv
// Bench for dncnt8_timer: table of directed vectors, hand-written reset and
// reload=step sequences, then random traffic against an integer reference model.
module tb_dncnt8_timer;

   logic       clk;
   logic       reset_n;
   logic       start, stop, en, mode;
   logic [7:0] load_val, step;
   logic [7:0] count;
   logic       busy, done, tc, uflow;

   int total = 0;
   int bad   = 0;

   // Reference model state: 0 = idle, 1 = run, 2 = done
   int m_state, m_count, m_reload, m_step, m_mode, m_tc, m_uflow;

   typedef struct {
      int st, sp, e, md, ld, stp;
      int x_count, x_busy, x_done, x_tc, x_uflow;
   } vec_t;

   vec_t tbl[$];

   dncnt8_timer #(.WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .en(en),
      .mode(mode), .load_val(load_val), .step(step), .count(count),
      .busy(busy), .done(done), .tc(tc), .uflow(uflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int c, input int b,
                          input int d, input int t, input int u);
      chk({tag, ".count"}, int'(count), c);
      chk({tag, ".busy"},  int'(busy),  b);
      chk({tag, ".done"},  int'(done),  d);
      chk({tag, ".tc"},    int'(tc),    t);
      chk({tag, ".uflow"}, int'(uflow), u);
   endtask

   task automatic chk_model(input string tag);
      chk_all(tag, m_count, int'(m_state == 1), int'(m_state == 2), m_tc, m_uflow);
   endtask

   task automatic model_reset();
      m_state = 0; m_count = 0; m_reload = 0; m_step = 0;
      m_mode = 0; m_tc = 0; m_uflow = 0;
   endtask

   // Applies the timer rules with plain integer arithmetic for one clock edge.
   task automatic model_edge();
      int new_tc;
      new_tc = 0;
      if (m_state == 1) begin
         if (stop) begin
            m_state = 0;
         end else if (en) begin
            if (m_count <= m_step) begin
               new_tc  = 1;
               m_uflow = (m_count < m_step) ? 1 : 0;
               if (m_mode == 1) begin
                  m_count = m_reload;
               end else begin
                  m_count = 0;
                  m_state = 2;
               end
            end else begin
               m_count = m_count - m_step;
            end
         end
      end else if (start && load_val != 0 && step != 0) begin
         m_count  = int'(load_val);
         m_reload = int'(load_val);
         m_step   = int'(step);
         m_mode   = int'(mode);
         m_uflow  = 0;
         m_state  = 1;
      end
      m_tc = new_tc;
   endtask

   task automatic drive(input int st, input int sp, input int e, input int md,
                        input int ld, input int stp);
      start    = st[0];
      stop     = sp[0];
      en       = e[0];
      mode     = md[0];
      load_val = ld[7:0];
      step     = stp[7:0];
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic add(input int st, input int sp, input int e, input int md,
                      input int ld, input int stp, input int c, input int b,
                      input int d, input int t, input int u);
      vec_t v;
      v = '{st, sp, e, md, ld, stp, c, b, d, t, u};
      tbl.push_back(v);
   endtask

   initial begin
      string tag;
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #2;
      chk_all("por", 0, 0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset mid-run: load 200 step 1, five enabled cycles, then async reset.
      drive(1, 0, 1, 0, 200, 1);
      cycle();
      chk_model("rst_start");
      drive(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle();
      chk_all("rst_run", 195, 1, 0, 0, 0);
      #3;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk_all("rst_async", 0, 0, 0, 0, 0);
      @(negedge clk);
      reset_n = 1'b1;

      //  st sp en md  ld  stp   count busy done tc uflow
      add(1, 0, 1, 0,   9,   3,    9, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    6, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    3, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    0, 0, 1, 1, 0);
      add(0, 0, 1, 0,   0,   0,    0, 0, 1, 0, 0);
      add(1, 0, 1, 1,   2,   1,    2, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    1, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    2, 1, 0, 1, 0);
      add(0, 0, 1, 0,   0,   0,    1, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    2, 1, 0, 1, 0);
      add(0, 1, 1, 0,   0,   0,    2, 0, 0, 0, 0);
      add(1, 0, 1, 0,  10,   3,   10, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    7, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    4, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    1, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    0, 0, 1, 1, 1);
      add(1, 0, 1, 0, 255, 255,  255, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    0, 0, 1, 1, 0);
      add(1, 0, 1, 1,   5,   2,    5, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    3, 1, 0, 0, 0);
      add(0, 0, 0, 0,   0,   0,    3, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    1, 1, 0, 0, 0);
      add(0, 0, 0, 0,   0,   0,    1, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    5, 1, 0, 1, 1);
      add(0, 0, 0, 0,   0,   0,    5, 1, 0, 0, 1);
      add(0, 0, 1, 0,   0,   0,    3, 1, 0, 0, 1);
      add(0, 1, 1, 0,   0,   0,    3, 0, 0, 0, 1);
      add(1, 0, 1, 0,   8,   2,    8, 1, 0, 0, 0);
      add(1, 0, 1, 0, 100,   1,    6, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    4, 1, 0, 0, 0);
      add(1, 1, 1, 0,   9,   1,    4, 0, 0, 0, 0);
      add(1, 0, 1, 0,   0,   3,    4, 0, 0, 0, 0);
      add(1, 0, 1, 0,   6,   0,    4, 0, 0, 0, 0);
      add(1, 0, 1, 0,   6,   6,    6, 1, 0, 0, 0);
      add(0, 0, 1, 0,   0,   0,    0, 0, 1, 1, 0);
      add(0, 1, 1, 0,   0,   0,    0, 0, 1, 0, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].sp, tbl[i].e, tbl[i].md, tbl[i].ld, tbl[i].stp);
         cycle();
         tag = $sformatf("vec%0d", i);
         chk_all(tag, tbl[i].x_count, tbl[i].x_busy, tbl[i].x_done,
                 tbl[i].x_tc, tbl[i].x_uflow);
      end

      // Periodic with reload equal to step: tc every enabled cycle, count pinned.
      drive(1, 0, 1, 1, 7, 7);
      cycle();
      chk_all("rs_start", 7, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk_all($sformatf("rs%0d", i), 7, 1, 0, 1, 0);
      end
      drive(0, 1, 1, 0, 0, 0);
      cycle();
      chk_all("rs_stop", 7, 0, 0, 0, 0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         int ld, stp;
         ld  = ($urandom % 8 == 0) ? 0 : int'($urandom % 256);
         if ($urandom % 8 == 0) stp = 0;
         else if ($urandom % 2 == 0) stp = int'($urandom % 8);
         else stp = int'($urandom % 256);
         drive(int'($urandom % 4 == 0), int'($urandom % 16 == 0),
               int'($urandom % 4 != 0), int'($urandom % 2), ld, stp);
         cycle();
         chk_model($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
